sd_block_arbiter: RTL and testbench
===================================

Name: sd_block_arbiter

Overview:
- Round-robin arbiter and transaction sequencer that shares one SD card controller between NUM_REQ block requesters (e.g. loader, logger).
- Latches the winning requester's op and block address, then pulses the controller's execute.
- Demuxes per-byte read data and write-byte acknowledges to the winner, counts bytes to BLOCK_BYTES, and reports done/error per requester.
- Sits directly above the SD card controller; the controller's init sequence completes before any grant is issued.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
BLOCK_BYTES, 512, data bytes per block transaction
IDX_W, 9, width of byte index (clog2 BLOCK_BYTES)
TIMEOUT_CYCLES, 1000000, byte-gap watchdog limit (used only with SD_ARB_TIMEOUT_EN)

Ports:
clk  in  1  master clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
req  in  NUM_REQ  per-requester transaction request, level
req_op  in  NUM_REQ  per-requester op: 0 READ, 1 WRITE
req_addr  in  32*NUM_REQ  per-requester block address, slice i = [32i+31:32i]
wr_data  in  8*NUM_REQ  per-requester next write byte
grant  out  NUM_REQ  one-hot owner; held for the whole transaction
done  out  NUM_REQ  1-cycle completion pulse to owner
err  out  NUM_REQ  1-cycle timeout pulse to owner (feature only)
wr_ack  out  NUM_REQ  1-cycle pulse: owner's wr_data byte consumed, present the next byte
rd_valid  out  1  1-cycle pulse: rd_byte/rd_index valid
rd_byte  out  8  read data byte
rd_index  out  IDX_W  byte offset within block, 0..BLOCK_BYTES-1
ctl_execute  out  1  1-cycle start pulse to SD controller
ctl_op_code  out  1  latched op
ctl_block_address  out  32  latched address
ctl_outgoing_byte  out  8  wr_data slice of owner; 0 when no owner
ctl_busy  in  1  SD controller busy (init or transaction)
ctl_finished_byte  in  1  byte read/written strobe
ctl_finished_block  in  1  transaction complete strobe
ctl_incoming_byte  in  8  read byte, valid with ctl_finished_byte

Behaviour:
- Reset values: every output 0; state IDLE; rr_ptr=0; byte count=0. Reset is honoured mid-transaction: grant drops immediately and no done/err pulse is issued.
- The ctl_* strobe inputs are synchronous to clk and sampled on the rising edge.
- IDLE:
  - Arbitrate only when |req and !ctl_busy.
  - Winner is the first set req bit scanning from rr_ptr upward with wrap.
  - On the arbitration edge: grant, ctl_op_code and ctl_block_address are latched; go to ISSUE.
- ISSUE:
  - ctl_execute=1 for exactly this one cycle; byte count cleared; go to XFER.
  - Latency from req high (bus idle) to ctl_execute is 2 cycles.
- XFER:
  - On ctl_finished_byte with op READ: next cycle rd_valid=1, rd_byte=ctl_incoming_byte, rd_index=count; count++.
  - On ctl_finished_byte with op WRITE: wr_ack[owner]=1 for one cycle; count++.
  - Completion occurs on ctl_finished_block, or when count reaches BLOCK_BYTES, whichever comes first; then go to DONE.
  - If ctl_finished_byte and ctl_finished_block arrive together, the byte is delivered first and completion follows in the same step.
  - Strobes arriving after count==BLOCK_BYTES are ignored (no rd_valid or wr_ack).
- DONE:
  - done[owner]=1 for one cycle; grant cleared; rr_ptr=(owner+1) mod NUM_REQ; return to IDLE.
  - This gives a minimum of 1 idle cycle between transactions.
- Requests during a transaction:
  - Owner dropping req mid-transaction has no effect; the transaction runs to completion.
  - Other requests wait; there is no pre-emption.
  - An owner still holding req after done is re-arbitrated fairly and loses to any other pending requester.
- req_op and req_addr are sampled only on the arbitration edge; later changes are ignored.
- ctl_finished_byte or ctl_finished_block seen in IDLE or ISSUE is discarded.
- Arithmetic:
  - rd_index wraps modulo 2^IDX_W; BLOCK_BYTES must be ≤ 2^IDX_W.
  - rr_ptr wraps modulo NUM_REQ.

Optional Feature:
SD_ARB_TIMEOUT_EN
- Defined:
  - A gap counter is cleared on ISSUE and on every ctl_finished_byte, and increments each cycle in XFER.
  - Reaching TIMEOUT_CYCLES raises err[owner]=1 for one cycle instead of done, and the block enters ABORT.
  - ABORT holds grant=0 and waits for ctl_busy=0, then returns to IDLE with rr_ptr advanced.
- Undefined: no counter and no ABORT state; err is tied to 0; XFER waits indefinitely.

Test Plan:
- Single read: req[0]=1, op 0, addr 0x00000010; model supplies 512 bytes 0x00..0xFF repeating, then finished_block -> ctl_execute 2 cycles after req, ctl_block_address=0x10, 512 rd_valid pulses with index 0..511 and matching data, done[0] once, grant released.
- Contention: req=2'b11 from idle, rr_ptr=0 -> req0 served first, then req1; with req0 held high, the third grant goes to req1 only if req1 re-requests, else req0 after 1 idle cycle.
- Write: req[1]=1, op 1, wr_data[1] updated on each wr_ack -> ctl_outgoing_byte tracks the owner's slice, 512 wr_ack pulses, done[1].
- Boundaries: finished_byte and finished_block on the same edge at byte 100 -> rd_index 100 delivered, then done; 3 extra finished_byte after byte 511 -> no extra rd_valid.
- Reset at byte 37 -> grant, rd_valid and done all 0 next edge; new req is arbitrated normally after reset deasserts; ctl_busy=1 at start holds off grant until it falls.
- With SD_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=50, model stalls after 10 bytes -> err[0] pulse exactly 50 cycles after byte 10, no done, IDLE after ctl_busy falls.

Source files
------------

// File: rtl/sd_block_arbiter.sv
// sd_block_arbiter: round-robin arbiter and transaction sequencer that shares one
// SD card controller between NUM_REQ block requesters.
// Optional feature macro: SD_ARB_TIMEOUT_EN (byte-gap watchdog with ABORT state).
module sd_block_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned BLOCK_BYTES    = 512,
    parameter int unsigned IDX_W          = 9
`ifdef SD_ARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     req_op,
    input  logic [32*NUM_REQ-1:0]  req_addr,
    input  logic [8*NUM_REQ-1:0]   wr_data,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     done,
    output logic [NUM_REQ-1:0]     err,
    output logic [NUM_REQ-1:0]     wr_ack,
    output logic                   rd_valid,
    output logic [7:0]             rd_byte,
    output logic [IDX_W-1:0]       rd_index,
    output logic                   ctl_execute,
    output logic                   ctl_op_code,
    output logic [31:0]            ctl_block_address,
    output logic [7:0]             ctl_outgoing_byte,
    input  logic                   ctl_busy,
    input  logic                   ctl_finished_byte,
    input  logic                   ctl_finished_block,
    input  logic [7:0]             ctl_incoming_byte
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned SUM_W = PTR_W + 1;
    localparam int unsigned CNT_W = $clog2(BLOCK_BYTES + 1);
    localparam logic [SUM_W-1:0] NREQ_V   = SUM_W'(NUM_REQ);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_BYTES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_XFER  = 3'd2,
        S_DONE  = 3'd3,
        S_ABORT = 3'd4
    } state_e;

    state_e state_q, state_d;

    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               op_q, op_d;
    logic [31:0]        addr_q, addr_d;
    logic               exec_q, exec_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               rd_valid_q, rd_valid_d;
    logic [7:0]         rd_byte_q, rd_byte_d;
    logic [IDX_W-1:0]   rd_index_q, rd_index_d;
    logic [NUM_REQ-1:0] wr_ack_q, wr_ack_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [7:0]         out_byte_q, out_byte_d;

    logic [31:0]        addr_arr [NUM_REQ];
    logic [7:0]         wdat_arr [NUM_REQ];
    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic [SUM_W-1:0]   cand_sum;
    logic [SUM_W-1:0]   owner_inc;
    logic [PTR_W-1:0]   ptr_next;
    logic [CNT_W-1:0]   count_inc;
    logic               arb_go;
    logic               byte_take;
    logic               xfer_complete;

`ifdef SD_ARB_TIMEOUT_EN
    localparam int unsigned GAP_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT_CYCLES);

    logic [NUM_REQ-1:0] err_q, err_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [GAP_W-1:0]   gap_inc;
    logic               gap_expired;

    assign gap_inc     = gap_q + GAP_W'(1);
    assign gap_expired = (state_q == S_XFER) && !ctl_finished_byte && (gap_inc == GAP_LIMIT);
`endif

    function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

    // Split the flat per-requester buses into indexable arrays
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            addr_arr[i] = req_addr[32*i +: 32];
            wdat_arr[i] = wr_data[8*i +: 8];
        end
    end

    // Round-robin pick: first set req bit scanning upward from rr_ptr with wrap
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_sum  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand_sum = {1'b0, rr_ptr_q} + SUM_W'(i);
            if (cand_sum >= NREQ_V) begin
                cand_sum = cand_sum - NREQ_V;
            end
            if (!win_found && req[cand_sum[PTR_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand_sum[PTR_W-1:0];
            end
        end
    end

    assign owner_inc     = {1'b0, owner_q} + SUM_W'(1);
    assign ptr_next      = (owner_inc == NREQ_V) ? '0 : owner_inc[PTR_W-1:0];
    assign count_inc     = count_q + CNT_W'(1);
    assign arb_go        = win_found && !ctl_busy;
    assign byte_take     = (state_q == S_XFER) && ctl_finished_byte && (count_q != LAST_CNT);
    assign xfer_complete = (state_q == S_XFER) &&
                           (ctl_finished_block || (byte_take && (count_inc == LAST_CNT)));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (arb_go) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_XFER;
            S_XFER: begin
                if (xfer_complete) begin
                    state_d = S_DONE;
                end
`ifdef SD_ARB_TIMEOUT_EN
                else if (gap_expired) begin
                    state_d = S_ABORT;
                end
`endif
            end
            S_DONE: state_d = S_IDLE;
`ifdef SD_ARB_TIMEOUT_EN
            S_ABORT: begin
                if (!ctl_busy) begin
                    state_d = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        grant_d    = grant_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        op_d       = op_q;
        addr_d     = addr_q;
        exec_d     = 1'b0;
        count_d    = count_q;
        rd_valid_d = 1'b0;
        rd_byte_d  = rd_byte_q;
        rd_index_d = rd_index_q;
        wr_ack_d   = '0;
        done_d     = '0;
        out_byte_d = (|grant_q) ? wdat_arr[owner_q] : 8'h00;
`ifdef SD_ARB_TIMEOUT_EN
        err_d      = '0;
        gap_d      = gap_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (arb_go) begin
                    grant_d = onehot(win_idx);
                    owner_d = win_idx;
                    op_d    = req_op[win_idx];
                    addr_d  = addr_arr[win_idx];
                end
            end
            S_ISSUE: begin
                exec_d  = 1'b1;
                count_d = '0;
`ifdef SD_ARB_TIMEOUT_EN
                gap_d   = '0;
`endif
            end
            S_XFER: begin
                if (byte_take) begin
                    count_d = count_inc;
                    if (!op_q) begin
                        rd_valid_d = 1'b1;
                        rd_byte_d  = ctl_incoming_byte;
                        rd_index_d = IDX_W'(count_q);
                    end else begin
                        wr_ack_d = onehot(owner_q);
                    end
                end
`ifdef SD_ARB_TIMEOUT_EN
                gap_d = ctl_finished_byte ? '0 : gap_inc;
                if (!xfer_complete && gap_expired) begin
                    err_d   = onehot(owner_q);
                    grant_d = '0;
                end
`endif
            end
            S_DONE: begin
                done_d   = onehot(owner_q);
                grant_d  = '0;
                rr_ptr_d = ptr_next;
            end
`ifdef SD_ARB_TIMEOUT_EN
            S_ABORT: begin
                grant_d = '0;
                if (!ctl_busy) begin
                    rr_ptr_d = ptr_next;
                end
            end
`endif
            default: begin
                grant_d = '0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q    <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            op_q       <= 1'b0;
            addr_q     <= '0;
            exec_q     <= 1'b0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_byte_q  <= '0;
            rd_index_q <= '0;
            wr_ack_q   <= '0;
            done_q     <= '0;
            out_byte_q <= '0;
        end else begin
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            exec_q     <= exec_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            rd_byte_q  <= rd_byte_d;
            rd_index_q <= rd_index_d;
            wr_ack_q   <= wr_ack_d;
            done_q     <= done_d;
            out_byte_q <= out_byte_d;
        end
    end

`ifdef SD_ARB_TIMEOUT_EN
    // Watchdog registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= '0;
            gap_q <= '0;
        end else begin
            err_q <= err_d;
            gap_q <= gap_d;
        end
    end

    assign err = err_q;
`else
    assign err = '0;
`endif

    assign grant             = grant_q;
    assign done              = done_q;
    assign wr_ack            = wr_ack_q;
    assign rd_valid          = rd_valid_q;
    assign rd_byte           = rd_byte_q;
    assign rd_index          = rd_index_q;
    assign ctl_execute       = exec_q;
    assign ctl_op_code       = op_q;
    assign ctl_block_address = addr_q;
    assign ctl_outgoing_byte = out_byte_q;

endmodule

// File: tb/tb_sd_block_arbiter.sv
// tb_sd_block_arbiter: directed bench for sd_block_arbiter with a small SD controller model.
// Build with SD_ARB_TIMEOUT_EN defined to also exercise the byte-gap watchdog.
module tb_sd_block_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  req_op;
    logic [63:0] req_addr;
    logic [15:0] wr_data;
    logic [1:0]  grant;
    logic [1:0]  done;
    logic [1:0]  err;
    logic [1:0]  wr_ack;
    logic        rd_valid;
    logic [7:0]  rd_byte;
    logic [8:0]  rd_index;
    logic        ctl_execute;
    logic        ctl_op_code;
    logic [31:0] ctl_block_address;
    logic [7:0]  ctl_outgoing_byte;
    logic        ctl_busy;
    logic        ctl_finished_byte;
    logic        ctl_finished_block;
    logic [7:0]  ctl_incoming_byte;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned rd_cnt, rd_bad, done_cnt, wr_cnt, exec_cnt, exp_idx, wr_bad, err_cnt;
    logic [1:0]  done_last;
    logic [7:0]  wr_val;

    always #5 clk = ~clk;

    sd_block_arbiter #(
        .NUM_REQ(2),
        .BLOCK_BYTES(512),
        .IDX_W(9)
`ifdef SD_ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(50)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .req_op(req_op),
        .req_addr(req_addr),
        .wr_data(wr_data),
        .grant(grant),
        .done(done),
        .err(err),
        .wr_ack(wr_ack),
        .rd_valid(rd_valid),
        .rd_byte(rd_byte),
        .rd_index(rd_index),
        .ctl_execute(ctl_execute),
        .ctl_op_code(ctl_op_code),
        .ctl_block_address(ctl_block_address),
        .ctl_outgoing_byte(ctl_outgoing_byte),
        .ctl_busy(ctl_busy),
        .ctl_finished_byte(ctl_finished_byte),
        .ctl_finished_block(ctl_finished_block),
        .ctl_incoming_byte(ctl_incoming_byte)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock; sample just after the edge and update the requester-side model
    task automatic tick();
        @(posedge clk);
        #1;
        if (rd_valid) begin
            if (32'(rd_index) != exp_idx || rd_byte != exp_idx[7:0]) rd_bad++;
            exp_idx++;
            rd_cnt++;
        end
        if (|done) begin
            done_cnt++;
            done_last = done;
        end
        if (|err) err_cnt++;
        if (ctl_execute) exec_cnt++;
        if (|wr_ack) wr_cnt++;
        if (wr_ack[1]) begin
            wr_val        = wr_val + 8'd1;
            wr_data[15:8] = wr_val;
        end
    endtask

    task automatic clear_counts();
        rd_cnt = 0; rd_bad = 0; done_cnt = 0; wr_cnt = 0; exec_cnt = 0;
        exp_idx = 0; wr_bad = 0; done_last = 2'b00;
    endtask

    task automatic strobe(input logic [7:0] d);
        ctl_finished_byte = 1'b1;
        ctl_incoming_byte = d;
        tick();
        ctl_finished_byte = 1'b0;
    endtask

    task automatic block_end();
        ctl_finished_block = 1'b1;
        tick();
        ctl_finished_block = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = 2'b00; req_op = 2'b00; req_addr = '0; wr_data = 16'h005A;
        ctl_busy = 1'b0; ctl_finished_byte = 1'b0; ctl_finished_block = 1'b0;
        ctl_incoming_byte = 8'h00; wr_val = 8'h00; err_cnt = 0;
        clear_counts();
        tick(); tick();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_exec", 32'(ctl_execute), 32'h0);
        check("rst_rdv", 32'(rd_valid), 32'h0);
        check("rst_addr", ctl_block_address, 32'h0);
        check("rst_out", 32'(ctl_outgoing_byte), 32'h0);
        rst = 1'b0;
        tick();
        clear_counts();

        // Single read by requester 0
        req_addr[31:0] = 32'h0000_0010; req_op = 2'b00; req = 2'b01;
        tick();
        check("t1_grant", 32'(grant), 32'h1);
        check("t1_exec_early", 32'(ctl_execute), 32'h0);
        tick();
        check("t1_exec", 32'(ctl_execute), 32'h1);
        check("t1_addr", ctl_block_address, 32'h10);
        check("t1_op", 32'(ctl_op_code), 32'h0);
        req = 2'b00;
        for (int k = 0; k < 512; k++) strobe(8'(k));
        for (int k = 0; k < 3; k++) strobe(8'hEE);
        block_end();
        tick();
        check("t1_rd_cnt", rd_cnt, 32'd512);
        check("t1_rd_bad", rd_bad, 32'd0);
        check("t1_done_cnt", done_cnt, 32'd1);
        check("t1_done_who", 32'(done_last), 32'h1);
        check("t1_grant_rel", 32'(grant), 32'h0);
        check("t1_exec_cnt", exec_cnt, 32'd1);

        // Write by requester 1; slice 0 holds a distinct byte
        clear_counts();
        req_addr[63:32] = 32'h0000_ABCD; req_op = 2'b10; req = 2'b10;
        wr_val = 8'h00; wr_data = 16'h005A;
        tick();
        check("w_grant", 32'(grant), 32'h2);
        tick();
        check("w_exec", 32'(ctl_execute), 32'h1);
        check("w_op", 32'(ctl_op_code), 32'h1);
        check("w_addr", ctl_block_address, 32'h0000_ABCD);
        req = 2'b00;
        for (int k = 0; k < 512; k++) begin
            if (ctl_outgoing_byte != 8'(k)) wr_bad++;
            strobe(8'h00);
            tick();
        end
        tick();
        check("w_out_idle", 32'(ctl_outgoing_byte), 32'h0);
        check("w_ack_cnt", wr_cnt, 32'd512);
        check("w_bad", wr_bad, 32'd0);
        check("w_done_cnt", done_cnt, 32'd1);
        check("w_done_who", 32'(done_last), 32'h2);
        check("w_rd_cnt", rd_cnt, 32'd0);

        // Contention: both request with rr_ptr back at 0
        clear_counts();
        req_addr = {32'h0000_0200, 32'h0000_0100}; req_op = 2'b00; req = 2'b11;
        tick();
        check("c_grant0", 32'(grant), 32'h1);
        check("c_addr0", ctl_block_address, 32'h100);
        tick();
        exp_idx = 0;
        strobe(8'h00); strobe(8'h01);
        block_end();
        tick();
        check("c_done0", 32'(done), 32'h1);
        check("c_gap", 32'(grant), 32'h0);
        tick();
        check("c_grant1", 32'(grant), 32'h2);
        check("c_addr1", ctl_block_address, 32'h200);
        req = 2'b01;
        tick();
        exp_idx = 0;
        strobe(8'h00);
        block_end();
        tick();
        check("c_done1", 32'(done), 32'h2);
        tick();
        check("c_grant2", 32'(grant), 32'h1);
        req = 2'b00;
        tick();
        block_end();
        tick();
        check("c_done_cnt", done_cnt, 32'd3);
        check("c_rd_cnt", rd_cnt, 32'd3);
        check("c_rd_bad", rd_bad, 32'd0);

        // Byte and block strobes together at byte 100
        clear_counts();
        req_op = 2'b00; req = 2'b01;
        tick(); tick();
        req = 2'b00;
        for (int k = 0; k < 100; k++) strobe(8'(k));
        ctl_finished_byte = 1'b1; ctl_finished_block = 1'b1; ctl_incoming_byte = 8'd100;
        tick();
        ctl_finished_byte = 1'b0; ctl_finished_block = 1'b0;
        check("b_rdv", 32'(rd_valid), 32'h1);
        check("b_idx", 32'(rd_index), 32'd100);
        tick();
        check("b_done", 32'(done), 32'h1);
        check("b_rd_cnt", rd_cnt, 32'd101);
        check("b_rd_bad", rd_bad, 32'd0);

        // Reset mid-transaction at byte 37, then busy holds off arbitration
        clear_counts();
        req = 2'b01;
        tick(); tick();
        req = 2'b00;
        for (int k = 0; k < 38; k++) strobe(8'(k));
        rst = 1'b1;
        #1;
        check("r_grant", 32'(grant), 32'h0);
        check("r_rdv", 32'(rd_valid), 32'h0);
        ctl_busy = 1'b1; req = 2'b11;
        tick();
        rst = 1'b0;
        tick(); tick(); tick();
        check("r_hold", 32'(grant), 32'h0);
        check("r_no_done", done_cnt, 32'd0);
        ctl_busy = 1'b0;
        tick();
        check("r_after", 32'(grant), 32'h1);
        req = 2'b00;
        tick();
        block_end();
        tick();
        check("r_done_who", 32'(done_last), 32'h1);
        check("r_rd_cnt", rd_cnt, 32'd38);

`ifdef SD_ARB_TIMEOUT_EN
        // Watchdog: stall after 10 bytes
        begin
            int unsigned n;
            clear_counts();
            req = 2'b01;
            tick(); tick();
            req = 2'b00; ctl_busy = 1'b1;
            for (int k = 0; k < 10; k++) strobe(8'(k));
            n = 0;
            while (err == 2'b00 && n < 200) begin
                tick();
                n++;
            end
            check("to_lat", n, 32'd50);
            check("to_err_who", 32'(err), 32'h1);
            check("to_grant", 32'(grant), 32'h0);
            repeat (5) tick();
            check("to_abort_hold", 32'(grant), 32'h0);
            ctl_busy = 1'b0;
            tick();
            req = 2'b11;
            tick();
            check("to_rr", 32'(grant), 32'h2);
            check("to_no_done", done_cnt, 32'd0);
            req = 2'b00;
            tick();
            block_end();
            tick();
        end
        check("err_total", err_cnt, 32'd1);
`else
        check("err_total", err_cnt, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
